// File: rtl/pkg_ram.sv
// Shared RAM device operation codes used by the arbiter and by its RAM.
package pkg_ram;

  typedef enum logic [1:0] {
    RAM_NOP   = 2'd0,
    RAM_FETCH = 2'd1,
    RAM_STORE = 2'd2
  } ram_op_t;

endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single-ported RAM device.
//   Port A is a fetch-only instruction requester, port B a load/store requester.
//   Each transaction takes an ISSUE cycle (RAM operation driven) followed by a
//   RESP cycle (ack plus read data), so the RAM never sees two operations in a row.
//   Payload is never latched: requesters hold addr/dtype/we/wdata until ack.
// Configuration macro:
//   RAM_ARB_RR_EN defined   -> ties from IDLE go to the port not served last.
//   RAM_ARB_RR_EN undefined -> port B always wins ties (default build).
//   In both builds a pending request on the other port is served right after
//   a response, so alternating traffic runs back to back.
module ram_arbiter
  import pkg_ram::*;
#(
  parameter int ADDRW = 17,
  parameter int DTW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  // Port A: instruction fetch
  input  logic             req_a,
  input  logic [ADDRW-1:0] addr_a,
  input  logic [DTW-1:0]   dtype_a,
  output logic             ack_a,
  output logic [31:0]      rdata_a,
  // Port B: load/store
  input  logic             req_b,
  input  logic             we_b,
  input  logic [ADDRW-1:0] addr_b,
  input  logic [DTW-1:0]   dtype_b,
  input  logic [31:0]      wdata_b,
  output logic             ack_b,
  output logic [31:0]      rdata_b,
  // Shared RAM device
  output ram_op_t          ram_op,
  output logic [ADDRW-1:0] ram_addr,
  output logic [DTW-1:0]   ram_data_type,
  output logic [31:0]      ram_data_in,
  input  logic [31:0]      ram_data_out,
  // Status
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Grant encoding: 0 selects port A, 1 selects port B.
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  state_t state_q, state_d;
  logic   g_q, g_d;

  // Grant to use when both ports request while idle.
  logic   tie_grant_s;
  // Request level of the port that is not currently granted.
  logic   other_req_s;

`ifdef RAM_ARB_RR_EN
  logic   last_q, last_d;

  // Round-robin tie break: favour the port that was not served last.
  assign tie_grant_s = ~last_q;
`else
  // Fixed priority tie break: port B always wins.
  assign tie_grant_s = GRANT_B;
`endif

  assign other_req_s = (g_q == GRANT_B) ? req_a : req_b;

  // Op code for the granted port: A only fetches, B stores when we_b is set.
  function automatic ram_op_t grant_op(input logic grant, input logic we);
    ram_op_t op;
    if (grant == GRANT_B) begin
      op = we ? RAM_STORE : RAM_FETCH;
    end else begin
      op = RAM_FETCH;
    end
    return op;
  endfunction

  // Next-state, grant and last-served selection.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
`ifdef RAM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_a && req_b) begin
          state_d = ST_ISSUE;
          g_d     = tie_grant_s;
        end else if (req_a || req_b) begin
          state_d = ST_ISSUE;
          g_d     = req_b;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // The RAM completes in one cycle; the response always follows.
        state_d = ST_RESP;
      end
      ST_RESP: begin
`ifdef RAM_ARB_RR_EN
        last_d = g_q;
`endif
        // The acked port's own request is ignored here; it must drop after ack.
        if (other_req_s) begin
          state_d = ST_ISSUE;
          g_d     = ~g_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        g_d     = GRANT_A;
      end
    endcase
  end

  // State, grant and last-served registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      g_q     <= GRANT_A;
`ifdef RAM_ARB_RR_EN
      last_q  <= GRANT_A;
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
`ifdef RAM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // RAM command, acks, read data and busy decoded from the current state.
  always_comb begin
    ram_op        = RAM_NOP;
    ram_addr      = {ADDRW{1'b0}};
    ram_data_type = {DTW{1'b0}};
    ram_data_in   = 32'd0;
    ack_a         = 1'b0;
    ack_b         = 1'b0;
    rdata_a       = 32'd0;
    rdata_b       = 32'd0;
    busy          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_ISSUE: begin
        busy   = 1'b1;
        ram_op = grant_op(g_q, we_b);
        if (g_q == GRANT_B) begin
          ram_addr      = addr_b;
          ram_data_type = dtype_b;
          ram_data_in   = wdata_b;
        end else begin
          ram_addr      = addr_a;
          ram_data_type = dtype_a;
          ram_data_in   = 32'd0;
        end
      end
      ST_RESP: begin
        // Read data is forwarded only alongside its ack so idle rdata stays zero.
        busy = 1'b1;
        if (g_q == GRANT_B) begin
          ack_b   = 1'b1;
          rdata_b = ram_data_out;
        end else begin
          ack_a   = 1'b1;
          rdata_a = ram_data_out;
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter: a table of single transactions
// plus hand-written sequences for ties, held requests and reset mid-ISSUE.
module tb_ram_arbiter;
  import pkg_ram::*;

  localparam int ADDRW = 17;
  localparam int DTW   = 2;

`ifdef RAM_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req_a, req_b, we_b;
  logic [ADDRW-1:0] addr_a, addr_b;
  logic [DTW-1:0]   dtype_a, dtype_b;
  logic [31:0]      wdata_b;
  logic             ack_a, ack_b, busy;
  logic [31:0]      rdata_a, rdata_b;
  ram_op_t          ram_op;
  logic [ADDRW-1:0] ram_addr;
  logic [DTW-1:0]   ram_data_type;
  logic [31:0]      ram_data_in, ram_data_out;

  int checks   = 0;
  int failures = 0;

  ram_arbiter #(.ADDRW(ADDRW), .DTW(DTW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_a        (req_a),
    .addr_a       (addr_a),
    .dtype_a      (dtype_a),
    .ack_a        (ack_a),
    .rdata_a      (rdata_a),
    .req_b        (req_b),
    .we_b         (we_b),
    .addr_b       (addr_b),
    .dtype_b      (dtype_b),
    .wdata_b      (wdata_b),
    .ack_b        (ack_b),
    .rdata_b      (rdata_b),
    .ram_op       (ram_op),
    .ram_addr     (ram_addr),
    .ram_data_type(ram_data_type),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Simple word RAM: result of an op is visible in the following cycle.
  logic [31:0] mem [0:255];
  logic [31:0] rd_q = 32'd0;
  always @(posedge clk) begin
    if (ram_op == RAM_FETCH) begin
      rd_q <= mem[ram_addr[9:2]];
    end else if (ram_op == RAM_STORE) begin
      mem[ram_addr[9:2]] <= ram_data_in;
      rd_q <= ram_data_in;
    end
  end
  assign ram_data_out = rd_q;

  typedef struct {
    logic             port_b;
    logic             we;
    logic [ADDRW-1:0] addr;
    logic [DTW-1:0]   dtype;
    logic [31:0]      wdata;
    ram_op_t          exp_op;
    logic [31:0]      exp_din;
    logic             chk_rd;
    logic [31:0]      exp_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 1'b0; req_b = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; dtype_a = '0; dtype_b = '0; wdata_b = 32'd0;
  endtask

  task automatic do_reset(input string nm);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk({nm, "_op"},    32'(ram_op), 32'(RAM_NOP));
    chk({nm, "_busy"},  32'(busy),   32'd0);
    chk({nm, "_acks"},  32'({ack_a, ack_b}), 32'd0);
    chk({nm, "_rdata"}, rdata_a | rdata_b, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One isolated transaction from IDLE: op in cycle 1, ack in cycle 2.
  task automatic run_vec(input int k, input vec_t v);
    string p;
    p = $sformatf("v%0d", k);
    if (v.port_b) begin
      req_b = 1'b1; we_b = v.we; addr_b = v.addr; dtype_b = v.dtype; wdata_b = v.wdata;
    end else begin
      req_a = 1'b1; addr_a = v.addr; dtype_a = v.dtype;
    end
    chk({p, "_c0_op"},   32'(ram_op), 32'(RAM_NOP));
    chk({p, "_c0_busy"}, 32'(busy),   32'd0);
    tick();
    chk({p, "_c1_op"},    32'(ram_op),        32'(v.exp_op));
    chk({p, "_c1_addr"},  32'(ram_addr),      32'(v.addr));
    chk({p, "_c1_dtype"}, 32'(ram_data_type), 32'(v.dtype));
    chk({p, "_c1_din"},   ram_data_in,        v.exp_din);
    chk({p, "_c1_busy"},  32'(busy),          32'd1);
    chk({p, "_c1_acks"},  32'({ack_a, ack_b}), 32'd0);
    tick();
    chk({p, "_c2_op"},    32'(ram_op),   32'(RAM_NOP));
    chk({p, "_c2_addr"},  32'(ram_addr), 32'd0);
    chk({p, "_c2_din"},   ram_data_in,   32'd0);
    chk({p, "_c2_ack_a"}, 32'(ack_a),    32'(!v.port_b));
    chk({p, "_c2_ack_b"}, 32'(ack_b),    32'(v.port_b));
    if (v.port_b) begin
      chk({p, "_c2_rdata_a"}, rdata_a, 32'd0);
      if (v.chk_rd) chk({p, "_c2_rdata_b"}, rdata_b, v.exp_rd);
    end else begin
      chk({p, "_c2_rdata_b"}, rdata_b, 32'd0);
      if (v.chk_rd) chk({p, "_c2_rdata_a"}, rdata_a, v.exp_rd);
    end
    idle_inputs();
    tick();
    chk({p, "_c3_busy"},  32'(busy), 32'd0);
    chk({p, "_c3_acks"},  32'({ack_a, ack_b}), 32'd0);
    chk({p, "_c3_rdata"}, rdata_a | rdata_b, 32'd0);
  endtask

  // Both ports request from cycle 0; masks give the expected ack cycles.
  task automatic tie_seq(input string nm, input int last_c, input int drop_a,
                         input logic [15:0] ma, input logic [15:0] mb);
    logic prev_op, op_now;
    prev_op = 1'b0;
    addr_a = 17'h00010; dtype_a = 2'd2; req_a = 1'b1;
    addr_b = 17'h00104; dtype_b = 2'd2; we_b = 1'b0; wdata_b = 32'd0; req_b = 1'b1;
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) tick();
      chk($sformatf("%s_c%0d_ack_a", nm, c), 32'(ack_a), 32'(ma[c]));
      chk($sformatf("%s_c%0d_ack_b", nm, c), 32'(ack_b), 32'(mb[c]));
      chk($sformatf("%s_c%0d_rdata_a", nm, c), rdata_a, ma[c] ? 32'h0BADF00D : 32'd0);
      chk($sformatf("%s_c%0d_rdata_b", nm, c), rdata_b, mb[c] ? 32'h12345678 : 32'd0);
      op_now = (ram_op != RAM_NOP);
      chk($sformatf("%s_c%0d_adjacent_ops", nm, c), 32'(prev_op && op_now), 32'd0);
      prev_op = op_now;
      if (c == drop_a) req_a = 1'b0;
    end
    idle_inputs();
    tick();
    tick();
    chk({nm, "_drained_busy"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs [0:5];
  vec_t v_rd200;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[4]   = 32'hDEADBEEF;   // byte address 0x00010
    mem[128] = 32'hCAFEF00D;   // byte address 0x00200

    //          port  we    addr       dtype  wdata          exp_op     exp_din        chk   exp_rd
    vecs[0] = '{1'b0, 1'b0, 17'h00010, 2'd2, 32'h00000000, RAM_FETCH, 32'h00000000, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 17'h00104, 2'd2, 32'h12345678, RAM_STORE, 32'h12345678, 1'b0, 32'h00000000};
    vecs[2] = '{1'b1, 1'b0, 17'h00104, 2'd2, 32'hFFFF0000, RAM_FETCH, 32'hFFFF0000, 1'b1, 32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 17'h00104, 2'd1, 32'h00000000, RAM_FETCH, 32'h00000000, 1'b1, 32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 17'h00010, 2'd0, 32'h0BADF00D, RAM_STORE, 32'h0BADF00D, 1'b0, 32'h00000000};
    vecs[5] = '{1'b0, 1'b0, 17'h00010, 2'd2, 32'h00000000, RAM_FETCH, 32'h00000000, 1'b1, 32'h0BADF00D};
    v_rd200 = '{1'b1, 1'b0, 17'h00200, 2'd2, 32'h00000000, RAM_FETCH, 32'h00000000, 1'b1, 32'hCAFEF00D};

    idle_inputs();
    #2;
    do_reset("rst0");

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Tie after reset, both held: B, A, B, A with acks in cycles 2, 4, 6, 8.
    do_reset("rst1");
    tie_seq("tie_held", 8, -1, 16'h0110, 16'h0044);

    // Tie after reset, A dropped at its first ack: B, A, then B alone.
    do_reset("rst2");
    tie_seq("tie_drop_a", 9, 4, 16'h0010, 16'h0244);

    // Held req_a alone: acks in cycles 2 and 5, IDLE in cycle 3.
    idle_inputs();
    addr_a = 17'h00010; dtype_a = 2'd2; req_a = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) tick();
      chk($sformatf("held_a_c%0d_ack", c),  32'(ack_a), 32'(c == 2 || c == 5));
      chk($sformatf("held_a_c%0d_busy", c), 32'(busy),  32'(c == 1 || c == 2 || c == 4 || c == 5));
      chk($sformatf("held_a_c%0d_op", c),   32'(ram_op),
          (c == 1 || c == 4) ? 32'(RAM_FETCH) : 32'(RAM_NOP));
    end
    chk("held_a_c5_rdata", rdata_a, 32'h0BADF00D);
    idle_inputs();
    tick();

    // Reset pulsed in the middle of an ISSUE of a B store to 0x00200.
    req_b = 1'b1; we_b = 1'b1; addr_b = 17'h00200; dtype_b = 2'd2; wdata_b = 32'h55AA55AA;
    tick();
    chk("rst_issue_c1_op", 32'(ram_op), 32'(RAM_STORE));
    #4;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_issue_op_now",   32'(ram_op),   32'(RAM_NOP));
    chk("rst_issue_busy_now", 32'(busy),     32'd0);
    chk("rst_issue_addr_now", 32'(ram_addr), 32'd0);
    tick();
    chk("rst_issue_ack_in_rst", 32'(ack_b), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rst_issue_no_ack_%0d", c), 32'({ack_a, ack_b}), 32'd0);
    end
    run_vec(6, v_rd200);

    // Tie from IDLE after a B transaction: round-robin picks A, fixed picks B.
    addr_a = 17'h00010; dtype_a = 2'd2; req_a = 1'b1;
    addr_b = 17'h00104; dtype_b = 2'd2; we_b = 1'b0; req_b = 1'b1;
    tick();
    chk("tie_idle_addr", 32'(ram_addr), RR_BUILD ? 32'h00010 : 32'h00104);
    tick();
    chk("tie_idle_ack_a", 32'(ack_a), 32'(RR_BUILD));
    chk("tie_idle_ack_b", 32'(ack_b), 32'(!RR_BUILD));
    idle_inputs();
    tick();
    tick();
    chk("tie_idle_drained", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
